// File: rtl/seq_div.sv
// Restoring divider: quotient/remainder DW_DEND cycles after an accepted start (1 cycle for a zero divisor with DIV_ZERO_FAST_EN).
// Start is accepted in IDLE or in the done cycle (back-to-back) and ignored while busy.
module seq_div #(
  parameter int DW_DEND = 8,
  parameter int DW_DSOR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DW_DEND-1:0] dividend,
  input  logic [DW_DSOR-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [DW_DEND-1:0] quotient,
  output logic [DW_DSOR-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = (DW_DEND > 1) ? $clog2(DW_DEND) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DW_DEND - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // r_dq starts as the dividend and fills with quotient bits from the bottom
  logic [DW_DEND-1:0] r_dq;
  logic [DW_DSOR:0]   r_rem;
  logic [DW_DSOR-1:0] r_dsor;
  logic [CW-1:0]      r_cnt;
  logic [DW_DEND-1:0] r_quot;
  logic [DW_DSOR-1:0] r_remo;
  logic               r_dbz;

  logic               w_accept;
  logic               w_last;
  logic               w_zero_skip;
  logic [DW_DSOR:0]   w_rem_shift;
  logic               w_ge;
  logic [DW_DSOR:0]   w_rem_nxt;
  logic [DW_DEND-1:0] w_dq_nxt;

`ifdef DIV_ZERO_FAST_EN
  assign w_zero_skip = (r_dsor == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // One restoring step: trial-subtract the divisor from the shifted partial remainder
  always_comb begin
    w_rem_shift = {r_rem[DW_DSOR-1:0], r_dq[DW_DEND-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_dsor});
    w_rem_nxt   = w_ge ? (w_rem_shift - {1'b0, r_dsor}) : w_rem_shift;
    w_dq_nxt    = {r_dq[DW_DEND-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_zero_skip || (r_cnt == LAST_CNT)) begin
          w_last      = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq   <= '0;
      r_rem  <= '0;
      r_dsor <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_dq   <= dividend;
      r_rem  <= '0;
      r_dsor <= divisor;
      r_cnt  <= '0;
    end else if ((r_state == S_RUN) && !w_zero_skip) begin
      r_dq   <= w_dq_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Result registers load only on FIN entry and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else if (w_last) begin
      if (w_zero_skip) begin
        r_quot <= '1;
        r_remo <= r_dq[DW_DSOR-1:0];
        r_dbz  <= 1'b1;
      end else begin
        r_quot <= w_dq_nxt;
        r_remo <= w_rem_nxt[DW_DSOR-1:0];
        r_dbz  <= (r_dsor == '0);
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed cases plus random traffic, scoreboarded against a / and % model.
module tb_seq_div;

  localparam int DW_DEND = 8;
  localparam int DW_DSOR = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [DW_DEND-1:0] dividend;
  logic [DW_DSOR-1:0] divisor;
  logic               busy;
  logic               done;
  logic [DW_DEND-1:0] quotient;
  logic [DW_DSOR-1:0] remainder;
  logic               div_by_zero;

  seq_div #(.DW_DEND(DW_DEND), .DW_DSOR(DW_DSOR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    int q;
    int r;
    int dbz;
    int acc;
    int dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_done = 0;
  int   vec = 0;
  int   mis = 0;
  exp_t mon_e;
  int   mon_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    vec++;
    if (act != exp_v) begin
      mis++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Model: accepted iff the DUT is idle or in its done cycle; result from / and %
  task automatic step(input bit s, input int a, input int b);
    int   lat;
    exp_t e;
    start    = s;
    dividend = a[DW_DEND-1:0];
    divisor  = b[DW_DSOR-1:0];
    if (s && cyc >= last_done) begin
`ifdef DIV_ZERO_FAST_EN
      lat = (b == 0) ? 1 : DW_DEND;
`else
      lat = DW_DEND;
`endif
      if (b == 0) begin
        e.q   = (1 << DW_DEND) - 1;
        e.r   = a % (1 << DW_DSOR);
        e.dbz = 1;
      end else begin
        e.q   = a / b;
        e.r   = a % b;
        e.dbz = 0;
      end
      e.acc = cyc + 1;
      e.dn  = cyc + 1 + lat;
      last_done = e.dn;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_busy = (sb.size() > 0 && cyc >= sb[0].acc && cyc < sb[0].dn) ? 1 : 0;
      chk("busy", int'(busy), mon_busy);
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.dn);
          chk("quotient", int'(quotient), mon_e.q);
          chk("remainder", int'(remainder), mon_e.r);
          chk("div_by_zero", int'(div_by_zero), mon_e.dbz);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].dn) begin
        mon_e = sb.pop_front();
        chk("done_missing", int'(done), 1);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    step(1'b1, 200, 7);  idle(10);
    step(1'b1, 255, 1);  idle(10);
    step(1'b1, 5, 9);    idle(10);
    step(1'b1, 0, 3);    idle(10);
    step(1'b1, 100, 0);  idle(10);

    // Start while busy is ignored
    step(1'b1, 200, 7);  idle(3);
    step(1'b1, 50, 3);   idle(8);

    // Start held through the done cycle chains a second division
    step(1'b1, 200, 7);
    repeat (DW_DEND + 1) step(1'b1, 99, 10);
    idle(12);

    // Reset mid-operation abandons the division
    step(1'b1, 200, 7);  idle(3);
    rst_n = 1'b0;
    sb.delete();
    last_done = 0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 15, 4);   idle(12);

    // Random traffic, including ignored and back-to-back starts
    repeat (2000) begin
      step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    if (sb.size() > 0) chk("drain_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
